// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, access-size codes, MEM FSM states
// and the store formatting / alignment helpers used by the MEM stage.
package cpu_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } mem_state_t;

  // Reserved size 2'b11 behaves as a word.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (size == SZ_BYTE): bad = 1'b0;
      (size == SZ_HALF): bad = lo[0];
      default:           bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byteEn(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      (size == SZ_BYTE): be = 4'b0001 << lo;
      (size == SZ_HALF): be = lo[1] ? 4'b1100 : 4'b0011;
      default:           be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] storeData(
    input logic [1:0]  size,
    input logic [31:0] wdata
  );
    logic [31:0] d;
    d = wdata;
    unique case (1'b1)
      (size == SZ_BYTE): d = {4{wdata[7:0]}};
      (size == SZ_HALF): d = {2{wdata[15:0]}};
      default:           d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select plus sign/zero extension.
// Ports: rdata (raw word), addrLo, size, isUnsigned -> data.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  output logic [31:0] data
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = rdata[{addrLo, 3'b000} +: 8];
    halfLane = addrLo[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    unique case (1'b1)
      (size == SZ_BYTE):
        data = {{24{byteLane[7] & ~isUnsigned}}, byteLane};
      (size == SZ_HALF):
        data = {{16{halfLane[15] & ~isUnsigned}}, halfLane};
      default:
        data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/gnt/rvalid port, stall, load
// align, MEM/WB register. Ports: ex_* in, dmem_* port, mem_stall, wb_*.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_stall,
  output logic              misalign,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data
);

  mem_state_t state, nextState;

  logic [DATA_W-1:0] lAddr, lWdata;
  logic [1:0]        lSize;
  logic              lUns, lWe, lRegWrite;
  logic [4:0]        lRd;
  logic [3:0]        lBe;

  logic              memOp, badAlign, latch;
  logic              stall, mis, reqActive;
  logic              nValid, nRegWrite;
  logic [4:0]        nRd;
  logic [DATA_W-1:0] nData, loadData;

  load_align uAlign (
    .rdata      (dmem_rdata),
    .addrLo     (lAddr[1:0]),
    .size       (lSize),
    .isUnsigned (lUns),
    .data       (loadData)
  );

  always_comb begin
    memOp     = ex_valid & (ex_mem_read | ex_mem_write);
    badAlign  = misaligned(ex_size, ex_addr[1:0]);
    nextState = state;
    stall     = 1'b0;
    mis       = 1'b0;
    latch     = 1'b0;
    nValid    = 1'b0;
    nRd       = wb_rd;
    nRegWrite = wb_reg_write;
    nData     = wb_data;
    unique case (state)
      IDLE: begin
        if (memOp && badAlign) begin
          mis       = 1'b1;
          nValid    = 1'b1;
          nRd       = ex_rd;
          nRegWrite = 1'b0;
        end else if (memOp) begin
          latch     = 1'b1;
          stall     = 1'b1;
          nextState = REQ;
        end else if (ex_valid) begin
          nValid    = 1'b1;
          nRd       = ex_rd;
          nRegWrite = ex_reg_write;
          nData     = ex_addr;
        end
      end
      REQ: begin
        if (dmem_gnt && lWe) begin
          nValid    = 1'b1;
          nRd       = lRd;
          nRegWrite = 1'b0;
          nextState = IDLE;
        end else if (dmem_gnt) begin
          stall     = 1'b1;
          nextState = RESP;
        end else begin
          stall     = 1'b1;
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          nValid    = 1'b1;
          nRd       = lRd;
          nRegWrite = lRegWrite;
          nData     = loadData;
          nextState = IDLE;
        end else begin
          stall     = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Both flags derive from live EX inputs, so they are forced low
  // while reset is held.
  assign mem_stall  = rst_n & stall;
  assign misalign   = rst_n & mis;

  assign reqActive  = (state == REQ);
  assign dmem_req   = reqActive;
  assign dmem_we    = reqActive & lWe;
  assign dmem_addr  = reqActive ? {lAddr[DATA_W-1:2], 2'b00} : '0;
  assign dmem_be    = reqActive ? lBe : 4'b0000;
  assign dmem_wdata = reqActive ? lWdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lAddr        <= '0;
      lWdata       <= '0;
      lSize        <= SZ_BYTE;
      lUns         <= 1'b0;
      lWe          <= 1'b0;
      lRegWrite    <= 1'b0;
      lRd          <= '0;
      lBe          <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
    end else begin
      state        <= nextState;
      wb_valid     <= nValid;
      wb_rd        <= nRd;
      wb_reg_write <= nRegWrite;
      wb_data      <= nData;
      if (latch) begin
        lAddr     <= ex_addr;
        lSize     <= ex_size;
        lUns      <= ex_unsigned;
        lWe       <= ex_mem_write & ~ex_mem_read;
        lRegWrite <= ex_reg_write;
        lRd       <= ex_rd;
        lBe       <= byteEn(ex_size, ex_addr[1:0]);
        lWdata    <= storeData(ex_size, ex_wdata);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalign,
// mixed sequence and reset during an outstanding read.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall, misalign;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_size      (ex_size),
    .ex_unsigned  (ex_unsigned),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .mem_stall    (mem_stall),
    .misalign     (misalign),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .wb_data      (wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v, input logic rd, input logic wr,
                    input logic [1:0] sz, input logic un,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [4:0] dst, input logic rw);
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr;
    ex_size = sz; ex_unsigned = un; ex_addr = a; ex_wdata = wd;
    ex_rd = dst; ex_reg_write = rw;
  endtask

  initial begin
    rst_n = 1'b0;
    op(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 32'h0;
    #12;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_wbv", {31'b0, wb_valid}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_wbdata", wb_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // signed byte load at 0x1003
    op(1, 1, 0, 2'b00, 0, 32'h1003, 32'h0, 5'd5, 1);
    #1;
    chk("b_idle_stall", {31'b0, mem_stall}, 32'd1);
    chk("b_idle_req", {31'b0, dmem_req}, 32'd0);
    tick();
    dmem_gnt = 1;
    #1;
    chk("b_req", {31'b0, dmem_req}, 32'd1);
    chk("b_we", {31'b0, dmem_we}, 32'd0);
    chk("b_be", {28'b0, dmem_be}, 32'h8);
    chk("b_addr", dmem_addr, 32'h1000);
    chk("b_req_stall", {31'b0, mem_stall}, 32'd1);
    tick();
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h80FF_FF12;
    #1;
    chk("b_resp_req", {31'b0, dmem_req}, 32'd0);
    chk("b_resp_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    dmem_rvalid = 0;
    op(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
    #1;
    chk("b_wbv", {31'b0, wb_valid}, 32'd1);
    chk("b_wbdata", wb_data, 32'hFFFF_FF80);
    chk("b_wbrd", {27'b0, wb_rd}, 32'd5);
    chk("b_wbrw", {31'b0, wb_reg_write}, 32'd1);
    tick();
    chk("b_wbv_after", {31'b0, wb_valid}, 32'd0);

    // half store at 0x2002, grant on the 4th REQ cycle
    op(1, 0, 1, 2'b01, 0, 32'h2002, 32'h0000_BEEF, 5'd7, 1);
    #1;
    chk("h_idle_stall", {31'b0, mem_stall}, 32'd1);
    tick();
    ex_wdata = 32'h0;
    ex_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      dmem_gnt = (i == 3);
      #1;
      chk("h_req", {31'b0, dmem_req}, 32'd1);
      chk("h_we", {31'b0, dmem_we}, 32'd1);
      chk("h_wdata", dmem_wdata, 32'hBEEF_BEEF);
      chk("h_be", {28'b0, dmem_be}, 32'hC);
      chk("h_addr", dmem_addr, 32'h2000);
      chk("h_stall", {31'b0, mem_stall}, (i == 3) ? 32'd0 : 32'd1);
      tick();
    end
    dmem_gnt = 0;
    op(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
    #1;
    chk("h_wbv", {31'b0, wb_valid}, 32'd1);
    chk("h_wbrw", {31'b0, wb_reg_write}, 32'd0);
    chk("h_idle_req", {31'b0, dmem_req}, 32'd0);
    tick();

    // misaligned word load at 0x6
    op(1, 1, 0, 2'b10, 0, 32'h6, 32'h0, 5'd3, 1);
    #1;
    chk("m_pulse", {31'b0, misalign}, 32'd1);
    chk("m_req", {31'b0, dmem_req}, 32'd0);
    chk("m_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    op(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
    #1;
    chk("m_wbv", {31'b0, wb_valid}, 32'd1);
    chk("m_wbrw", {31'b0, wb_reg_write}, 32'd0);
    chk("m_pulse_end", {31'b0, misalign}, 32'd0);
    chk("m_req_after", {31'b0, dmem_req}, 32'd0);
    tick();

    // non-memory op then unsigned half load at 0x10
    op(1, 0, 0, 2'b10, 0, 32'h55, 32'h0, 5'd9, 1);
    #1;
    chk("x_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    op(1, 1, 0, 2'b01, 1, 32'h10, 32'h0, 5'd10, 1);
    #1;
    chk("x_wbv", {31'b0, wb_valid}, 32'd1);
    chk("x_wbdata", wb_data, 32'h55);
    chk("x_wbrd", {27'b0, wb_rd}, 32'd9);
    chk("x_ld_stall", {31'b0, mem_stall}, 32'd1);
    tick();
    dmem_gnt = 1;
    #1;
    chk("x_be", {28'b0, dmem_be}, 32'h3);
    chk("x_bubble", {31'b0, wb_valid}, 32'd0);
    tick();
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h1234_8001;
    #1;
    chk("x_resp_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    dmem_rvalid = 0;
    op(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
    #1;
    chk("x_ld_wbv", {31'b0, wb_valid}, 32'd1);
    chk("x_ld_wbdata", wb_data, 32'h0000_8001);
    chk("x_ld_wbrd", {27'b0, wb_rd}, 32'd10);
    tick();

    // reset while waiting in RESP
    op(1, 1, 0, 2'b10, 0, 32'h20, 32'h0, 5'd4, 1);
    tick();
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    #1;
    chk("r_resp_stall", {31'b0, mem_stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_req", {31'b0, dmem_req}, 32'd0);
    chk("r_stall", {31'b0, mem_stall}, 32'd0);
    chk("r_misalign", {31'b0, misalign}, 32'd0);
    chk("r_wbv", {31'b0, wb_valid}, 32'd0);
    chk("r_wbdata", wb_data, 32'h0);
    chk("r_addr", dmem_addr, 32'h0);
    op(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_rvalid = 0;
    #1;
    chk("r_late_wbv", {31'b0, wb_valid}, 32'd0);
    chk("r_late_stall", {31'b0, mem_stall}, 32'd0);
    chk("r_late_wbdata", wb_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
